// File: rtl/ppfifo_bridge_pkg.sv
// Shared definitions for the dual-port-buffer <-> ping-pong FIFO DMA bridge:
// controller state encoding, transfer direction codes and the FIFO size width.
package ppfifo_bridge_pkg;

    localparam int SIZE_W = 24;

    localparam logic DIR_MEM2PF = 1'b0;
    localparam logic DIR_PF2MEM = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SETUP,
        ST_WR_ISSUE,
        ST_WR_DRAIN,
        ST_RD_WAIT,
        ST_RD_XFER,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ppfifo_bridge_ram.sv
// True dual-port single-clock RAM. Each port's read data passes through
// READ_LATENCY output registers, so dout follows the address by READ_LATENCY cycles.
module ppfifo_bridge_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_we,
    input  logic [MEM_DEPTH-1:0]  a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_we,
    input  logic [MEM_DEPTH-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout
);

    logic [DATA_WIDTH-1:0] mem    [2**MEM_DEPTH];
    logic [DATA_WIDTH-1:0] a_pipe [READ_LATENCY];
    logic [DATA_WIDTH-1:0] b_pipe [READ_LATENCY];

    // NOTE: the storage array is deliberately not reset; a reset on it would stop block-RAM mapping.
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_din;
        if (b_we) mem[b_addr] <= b_din;
    end

    // Output registers are reset so both read ports come up at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                a_pipe[i] <= '0;
                b_pipe[i] <= '0;
            end
        end else begin
            a_pipe[0] <= mem[a_addr];
            b_pipe[0] <= mem[b_addr];
            for (int i = 1; i < READ_LATENCY; i++) begin
                a_pipe[i] <= a_pipe[i-1];
                b_pipe[i] <= b_pipe[i-1];
            end
        end
    end

    assign a_dout = a_pipe[READ_LATENCY-1];
    assign b_dout = b_pipe[READ_LATENCY-1];

endmodule

// File: rtl/dpb_ppfifo_dma.sv
// Command-driven DMA between a local dual-port buffer and a ping-pong FIFO pair.
// Optional transfer counters are built only when PPFIFO_BRIDGE_STATS_EN is defined.
module dpb_ppfifo_dma
    import ppfifo_bridge_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_stb,
    input  logic                  i_cmd_dir,
    input  logic [MEM_DEPTH-1:0]  i_cmd_addr,
    input  logic [SIZE_W-1:0]     i_cmd_len,
    input  logic                  i_cancel_stb,
    output logic                  o_busy,
    output logic                  o_done_stb,
    output logic                  o_cmd_err_stb,
    output logic [31:0]           o_num_reads,
    output logic [31:0]           o_num_writes,
    input  logic                  i_bram_we,
    input  logic [MEM_DEPTH-1:0]  i_bram_addr,
    input  logic [DATA_WIDTH-1:0] i_bram_din,
    output logic [DATA_WIDTH-1:0] o_bram_dout,
    input  logic [1:0]            i_write_ready,
    output logic [1:0]            o_write_activate,
    input  logic [SIZE_W-1:0]     i_write_size,
    output logic                  o_write_stb,
    output logic [DATA_WIDTH-1:0] o_write_data,
    input  logic                  i_read_ready,
    output logic                  o_read_activate,
    input  logic [SIZE_W-1:0]     i_read_size,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  o_read_stb
);

    state_t                  state, state_nx;
    logic [MEM_DEPTH-1:0]    addr_q, addr_nx;
    logic [SIZE_W-1:0]       len_q, len_nx;
    logic [SIZE_W-1:0]       n_q, n_nx;
    logic [SIZE_W-1:0]       count_q, count_nx;
    logic [1:0]              wr_act_q, wr_act_nx;
    logic                    rd_act_q, rd_act_nx;
    logic [READ_LATENCY-1:0] vpipe_q;
    logic                    issue;
    logic                    b_we;
    logic                    done_q, err_q;
    logic [DATA_WIDTH-1:0]   b_dout;

    ppfifo_bridge_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEM_DEPTH   (MEM_DEPTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .a_we  (i_bram_we),
        .a_addr(i_bram_addr),
        .a_din (i_bram_din),
        .a_dout(o_bram_dout),
        .b_we  (b_we),
        .b_addr(addr_q),
        .b_din (i_read_data),
        .b_dout(b_dout)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        addr_nx   = addr_q;
        len_nx    = len_q;
        n_nx      = n_q;
        count_nx  = count_q;
        wr_act_nx = wr_act_q;
        rd_act_nx = rd_act_q;
        issue     = 1'b0;
        b_we      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (i_cmd_stb) begin
                    addr_nx  = i_cmd_addr;
                    len_nx   = i_cmd_len;
                    state_nx = (i_cmd_dir == DIR_PF2MEM) ? ST_RD_WAIT : ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: begin
                if (i_write_ready != 2'b00 && wr_act_q == 2'b00) begin
                    wr_act_nx = i_write_ready[0] ? 2'b01 : 2'b10;
                    n_nx      = (len_q == '0 || len_q > i_write_size) ? i_write_size : len_q;
                    count_nx  = '0;
                    // An empty block still opens and closes the channel.
                    state_nx  = (n_nx == '0) ? ST_WR_DRAIN : ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                issue    = 1'b1;
                addr_nx  = addr_q + MEM_DEPTH'(1);
                count_nx = count_q + SIZE_W'(1);
                if (count_nx == n_q) state_nx = ST_WR_DRAIN;
            end
            ST_WR_DRAIN: begin
                if (vpipe_q == '0) begin
                    wr_act_nx = 2'b00;
                    state_nx  = ST_DONE;
                end
            end
            ST_RD_WAIT: begin
                if (i_read_ready) begin
                    rd_act_nx = 1'b1;
                    n_nx      = i_read_size;
                    count_nx  = '0;
                    state_nx  = ST_RD_XFER;
                end
            end
            ST_RD_XFER: begin
                if (count_q < n_q) begin
                    b_we     = 1'b1;
                    addr_nx  = addr_q + MEM_DEPTH'(1);
                    count_nx = count_q + SIZE_W'(1);
                end else begin
                    rd_act_nx = 1'b0;
                    state_nx  = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase

        if (i_cancel_stb) begin
            state_nx  = ST_IDLE;
            wr_act_nx = 2'b00;
            rd_act_nx = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            n_q      <= '0;
            count_q  <= '0;
            wr_act_q <= 2'b00;
            rd_act_q <= 1'b0;
            vpipe_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            addr_q   <= addr_nx;
            len_q    <= len_nx;
            n_q      <= n_nx;
            count_q  <= count_nx;
            wr_act_q <= wr_act_nx;
            rd_act_q <= rd_act_nx;
            vpipe_q  <= i_cancel_stb ? '0 : ((vpipe_q << 1) | READ_LATENCY'(issue));
            done_q   <= (state == ST_DONE) && !i_cancel_stb;
            err_q    <= i_cmd_stb && !i_cancel_stb && (state != ST_IDLE);
        end
    end

`ifdef PPFIFO_BRIDGE_STATS_EN
    logic        dir_q;
    logic [31:0] reads_q, writes_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q    <= DIR_MEM2PF;
            reads_q  <= '0;
            writes_q <= '0;
        end else begin
            if (state == ST_IDLE && i_cmd_stb && !i_cancel_stb) dir_q <= i_cmd_dir;
            if (state == ST_DONE && !i_cancel_stb) begin
                if (dir_q == DIR_PF2MEM) reads_q  <= reads_q + 32'd1;
                else                     writes_q <= writes_q + 32'd1;
            end
        end
    end

    assign o_num_reads  = reads_q;
    assign o_num_writes = writes_q;
`else
    assign o_num_reads  = '0;
    assign o_num_writes = '0;
`endif

    assign o_busy           = (state != ST_IDLE);
    assign o_done_stb       = done_q;
    assign o_cmd_err_stb    = err_q;
    assign o_write_activate = wr_act_q;
    assign o_write_stb      = vpipe_q[READ_LATENCY-1];
    assign o_write_data     = b_dout;
    assign o_read_activate  = rd_act_q;
    assign o_read_stb       = b_we;

endmodule

// File: tb/tb_dpb_ppfifo_dma.sv
// Bench for dpb_ppfifo_dma: three instances (read latency 1, 2, 3) share all inputs
// and are checked against a buffer model and the transfer rules.
module tb_dpb_ppfifo_dma;

    localparam int DW    = 32;
    localparam int MD    = 4;
    localparam int DEPTH = 16;
    localparam int NI    = 3;
`ifdef PPFIFO_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_stb = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [MD-1:0] cmd_addr = '0;
    logic [23:0]   cmd_len = '0;
    logic          cancel = 1'b0;
    logic          bram_we = 1'b0;
    logic [MD-1:0] bram_addr = '0;
    logic [DW-1:0] bram_din = '0;
    logic [1:0]    write_ready = 2'b00;
    logic [23:0]   write_size = '0;
    logic          read_ready = 1'b0;
    logic [23:0]   read_size = '0;
    logic [DW-1:0] read_data = '0;

    logic          busy [NI];
    logic          done [NI];
    logic          err  [NI];
    logic [31:0]   nreads [NI];
    logic [31:0]   nwrites [NI];
    logic [DW-1:0] bram_dout [NI];
    logic [1:0]    wact [NI];
    logic          wstb [NI];
    logic [DW-1:0] wdata [NI];
    logic          ract [NI];
    logic          rstb [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dpb_ppfifo_dma #(
            .DATA_WIDTH  (DW),
            .MEM_DEPTH   (MD),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .i_cmd_stb       (cmd_stb),
            .i_cmd_dir       (cmd_dir),
            .i_cmd_addr      (cmd_addr),
            .i_cmd_len       (cmd_len),
            .i_cancel_stb    (cancel),
            .o_busy          (busy[g]),
            .o_done_stb      (done[g]),
            .o_cmd_err_stb   (err[g]),
            .o_num_reads     (nreads[g]),
            .o_num_writes    (nwrites[g]),
            .i_bram_we       (bram_we),
            .i_bram_addr     (bram_addr),
            .i_bram_din      (bram_din),
            .o_bram_dout     (bram_dout[g]),
            .i_write_ready   (write_ready),
            .o_write_activate(wact[g]),
            .i_write_size    (write_size),
            .o_write_stb     (wstb[g]),
            .o_write_data    (wdata[g]),
            .i_read_ready    (read_ready),
            .o_read_activate (ract[g]),
            .i_read_size     (read_size),
            .i_read_data     (read_data),
            .o_read_stb      (rstb[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model_mem [DEPTH];
    int exp_writes = 0;
    int exp_reads  = 0;

    // Per-instance observations of one transfer.
    int            act_rise [NI];
    int            act_fall [NI];
    logic [1:0]    act_val  [NI];
    bit            act_bad  [NI];
    bit            prev_act [NI];
    int            stb_cnt  [NI];
    int            stb_first[NI];
    int            stb_last [NI];
    logic [DW-1:0] stb_data [NI][64];
    int            rd_cnt   [NI];
    int            rd_first [NI];
    int            rd_last  [NI];
    int            done_cnt [NI];
    int            done_cyc [NI];
    int            err_cnt  [NI];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_trk();
        for (int k = 0; k < NI; k++) begin
            act_rise[k] = -1; act_fall[k] = -1; act_val[k] = 2'b00; act_bad[k] = 1'b0;
            prev_act[k] = 1'b0; stb_cnt[k] = 0; stb_first[k] = -1; stb_last[k] = -1;
            rd_cnt[k] = 0; rd_first[k] = -1; rd_last[k] = -1;
            done_cnt[k] = 0; done_cyc[k] = -1; err_cnt[k] = 0;
        end
    endtask

    task automatic sample(input int cyc);
        for (int k = 0; k < NI; k++) begin
            logic act;
            act = (wact[k] != 2'b00) || ract[k];
            if (act && !prev_act[k]) begin
                act_rise[k] = cyc;
                act_val[k]  = wact[k];
            end else if (act && wact[k] != act_val[k]) begin
                act_bad[k] = 1'b1;
            end
            if (!act && prev_act[k]) act_fall[k] = cyc;
            prev_act[k] = act;
            if (wstb[k]) begin
                if (stb_cnt[k] == 0) stb_first[k] = cyc;
                if (stb_cnt[k] < 64) stb_data[k][stb_cnt[k]] = wdata[k];
                stb_cnt[k]++;
                stb_last[k] = cyc;
            end
            if (rstb[k]) begin
                if (rd_cnt[k] == 0) rd_first[k] = cyc;
                rd_cnt[k]++;
                rd_last[k] = cyc;
            end
            if (done[k]) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end
            if (err[k]) err_cnt[k]++;
        end
    endtask

    function automatic bit all_finished();
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < NI; k++)
            if (done_cnt[k] == 0 || busy[k]) ok = 1'b0;
        return ok;
    endfunction

    task automatic fill_mem(input int start, input int n, input bit use_addr);
        for (int i = 0; i < n; i++) begin
            int a;
            a = (start + i) % DEPTH;
            bram_we   = 1'b1;
            bram_addr = MD'(a);
            bram_din  = use_addr ? DW'(a) : $urandom();
            model_mem[a] = bram_din;
            step();
        end
        bram_we = 1'b0;
    endtask

    // Streams addresses on port A and checks each instance at its own latency.
    task automatic stream_check(input string name, input int start, input int n);
        for (int j = 0; j < n + NI; j++) begin
            if (j < n) bram_addr = MD'((start + j) % DEPTH);
            step();
            for (int k = 0; k < NI; k++) begin
                int idx;
                idx = j - k;
                if (idx >= 0 && idx < n) begin
                    n_tests++;
                    if (bram_dout[k] !== model_mem[(start + idx) % DEPTH]) begin
                        n_fail++;
                        $display("FAIL %s L%0d porta[%0d]: got %h expected %h", name, k + 1,
                                 (start + idx) % DEPTH, bram_dout[k], model_mem[(start + idx) % DEPTH]);
                    end
                end
            end
        end
    endtask

    task automatic run_write(input string name, input int start, input int len,
                             input int wsize, input logic [1:0] ready);
        int n;
        int cyc;
        logic [1:0] ch;
        n  = (len == 0 || len > wsize) ? wsize : len;
        ch = ready[0] ? 2'b01 : 2'b10;
        clear_trk();
        write_size  = 24'(wsize);
        write_ready = ready;
        cmd_dir     = 1'b0;
        cmd_addr    = MD'(start);
        cmd_len     = 24'(len);
        cmd_stb     = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
            cmd_stb = 1'b0;
            sample(cyc);
        end while (!all_finished() && cyc < 200);
        for (int t = 0; t < 4; t++) begin
            step();
            cyc++;
            sample(cyc);
        end
        write_ready = 2'b00;
        exp_writes++;
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (act_rise[k] != 2) begin
                n_fail++;
                $display("FAIL %s L%0d activate_rise: got %0d expected 2", name, k + 1, act_rise[k]);
            end
            n_tests++;
            if (act_val[k] !== ch || act_bad[k]) begin
                n_fail++;
                $display("FAIL %s L%0d activate_chan: got %b (unstable=%0d) expected %b",
                         name, k + 1, act_val[k], act_bad[k], ch);
            end
            n_tests++;
            if (stb_cnt[k] != n) begin
                n_fail++;
                $display("FAIL %s L%0d stb_count: got %0d expected %0d", name, k + 1, stb_cnt[k], n);
            end
            for (int i = 0; i < n && i < stb_cnt[k]; i++) begin
                n_tests++;
                if (stb_data[k][i] !== model_mem[(start + i) % DEPTH]) begin
                    n_fail++;
                    $display("FAIL %s L%0d word%0d: got %h expected %h", name, k + 1, i,
                             stb_data[k][i], model_mem[(start + i) % DEPTH]);
                end
            end
            n_tests++;
            if (n > 0) begin
                if (stb_first[k] != 2 + k + 1 || stb_last[k] - stb_first[k] + 1 != n
                    || act_fall[k] <= stb_last[k]) begin
                    n_fail++;
                    $display("FAIL %s L%0d stb_timing: got first=%0d last=%0d fall=%0d expected first=%0d span=%0d",
                             name, k + 1, stb_first[k], stb_last[k], act_fall[k], 3 + k, n);
                end
            end else if (act_fall[k] != 3) begin
                n_fail++;
                $display("FAIL %s L%0d empty_release: got fall=%0d expected 3", name, k + 1, act_fall[k]);
            end
            n_tests++;
            if (done_cnt[k] != 1 || done_cyc[k] != act_fall[k] + 1) begin
                n_fail++;
                $display("FAIL %s L%0d done: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                         name, k + 1, done_cnt[k], done_cyc[k], act_fall[k] + 1);
            end
            n_tests++;
            if (nwrites[k] !== (STATS ? 32'(exp_writes) : 32'd0)) begin
                n_fail++;
                $display("FAIL %s L%0d num_writes: got %0d expected %0d", name, k + 1,
                         nwrites[k], STATS ? exp_writes : 0);
            end
        end
    endtask

    task automatic run_read(input string name, input int start, input int n, input int err_at);
        logic [DW-1:0] data [64];
        int idx;
        int cyc;
        for (int i = 0; i < n; i++) data[i] = $urandom();
        clear_trk();
        idx        = 0;
        read_size  = 24'(n);
        read_ready = 1'b1;
        cmd_dir    = 1'b1;
        cmd_addr   = MD'(start);
        cmd_len    = '0;
        cmd_stb    = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
            cmd_stb = (cyc == err_at);
            sample(cyc);
            if (rstb[0] && idx < 64) begin
                read_data = data[idx];
                idx++;
            end else begin
                read_data = $urandom();
            end
        end while (!all_finished() && cyc < 200);
        cmd_stb = 1'b0;
        for (int t = 0; t < 4; t++) begin
            step();
            cyc++;
            sample(cyc);
        end
        read_ready = 1'b0;
        for (int i = 0; i < n; i++) model_mem[(start + i) % DEPTH] = data[i];
        exp_reads++;
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (act_rise[k] != 2 || wact[k] !== 2'b00) begin
                n_fail++;
                $display("FAIL %s L%0d read_activate_rise: got %0d expected 2", name, k + 1, act_rise[k]);
            end
            n_tests++;
            if (rd_cnt[k] != n) begin
                n_fail++;
                $display("FAIL %s L%0d read_stb_count: got %0d expected %0d", name, k + 1, rd_cnt[k], n);
            end
            if (n > 0) begin
                n_tests++;
                if (rd_first[k] < act_rise[k] || rd_first[k] > act_rise[k] + 1
                    || rd_last[k] - rd_first[k] + 1 != n || act_fall[k] <= rd_last[k]) begin
                    n_fail++;
                    $display("FAIL %s L%0d read_stb_timing: got first=%0d last=%0d rise=%0d fall=%0d expected span=%0d",
                             name, k + 1, rd_first[k], rd_last[k], act_rise[k], act_fall[k], n);
                end
            end
            n_tests++;
            if (done_cnt[k] != 1 || done_cyc[k] != act_fall[k] + 1) begin
                n_fail++;
                $display("FAIL %s L%0d done: got count=%0d cyc=%0d expected count=1 cyc=%0d",
                         name, k + 1, done_cnt[k], done_cyc[k], act_fall[k] + 1);
            end
            n_tests++;
            if (err_cnt[k] != ((err_at != 0) ? 1 : 0)) begin
                n_fail++;
                $display("FAIL %s L%0d cmd_err: got %0d expected %0d", name, k + 1,
                         err_cnt[k], (err_at != 0) ? 1 : 0);
            end
            n_tests++;
            if (nreads[k] !== (STATS ? 32'(exp_reads) : 32'd0)) begin
                n_fail++;
                $display("FAIL %s L%0d num_reads: got %0d expected %0d", name, k + 1,
                         nreads[k], STATS ? exp_reads : 0);
            end
        end
        stream_check(name, start, n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if ({busy[k], done[k], err[k], nreads[k], nwrites[k], bram_dout[k], wact[k],
                 wstb[k], wdata[k], ract[k], rstb[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset L%0d outputs: got busy=%b done=%b err=%b act=%b/%b stb=%b/%b dout=%h wdata=%h expected all 0",
                         k + 1, busy[k], done[k], err[k], wact[k], ract[k], wstb[k], rstb[k],
                         bram_dout[k], wdata[k]);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_write();
        fill_mem(0, 16, 1'b1);
        stream_check("basic_fill", 0, 16);
        run_write("basic_write", 0, 0, 16, 2'b01);
    endtask

    task automatic test_wrap_truncate();
        run_write("wrap", 14, 4, 16, 2'b01);
        run_write("truncate", 14, 20, 8, 2'b01);
    endtask

    task automatic test_channels();
        fill_mem(0, 16, 1'b0);
        run_write("chan1", 5, 6, 16, 2'b10);
        run_write("chan_both", 9, 3, 16, 2'b11);
        run_write("empty_block", 2, 0, 0, 2'b01);
    endtask

    task automatic test_read();
        run_read("read", 3, 5, 0);
    endtask

    task automatic test_busy_cmd();
        run_read("busy_cmd", 10, 6, 3);
    endtask

    task automatic test_cancel();
        int cyc;
        clear_trk();
        write_size  = 24'd16;
        write_ready = 2'b01;
        cmd_dir     = 1'b0;
        cmd_addr    = MD'(2);
        cmd_len     = 24'd10;
        cmd_stb     = 1'b1;
        cyc = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            cyc++;
            cmd_stb = 1'b0;
            cancel  = (cyc == 5);
            sample(cyc);
        end
        cancel = 1'b0;
        write_ready = 2'b00;
        for (int k = 0; k < NI; k++) begin
            n_tests++;
            if (stb_cnt[k] != 3 - k || stb_last[k] > 5) begin
                n_fail++;
                $display("FAIL cancel L%0d stb: got count=%0d last=%0d expected count=%0d last<=5",
                         k + 1, stb_cnt[k], stb_last[k], 3 - k);
            end
            for (int i = 0; i < stb_cnt[k] && i < 3 - k; i++) begin
                n_tests++;
                if (stb_data[k][i] !== model_mem[(2 + i) % DEPTH]) begin
                    n_fail++;
                    $display("FAIL cancel L%0d word%0d: got %h expected %h", k + 1, i,
                             stb_data[k][i], model_mem[(2 + i) % DEPTH]);
                end
            end
            n_tests++;
            if (act_fall[k] != 6 || busy[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL cancel L%0d release: got fall=%0d busy=%b expected fall=6 busy=0",
                         k + 1, act_fall[k], busy[k]);
            end
            n_tests++;
            if (done_cnt[k] != 0 || nwrites[k] !== (STATS ? 32'(exp_writes) : 32'd0)) begin
                n_fail++;
                $display("FAIL cancel L%0d done/count: got done=%0d writes=%0d expected done=0 writes=%0d",
                         k + 1, done_cnt[k], nwrites[k], STATS ? exp_writes : 0);
            end
        end
        // Cancel together with a command from idle drops the command.
        clear_trk();
        cmd_dir = 1'b1;
        cmd_stb = 1'b1;
        cancel  = 1'b1;
        step();
        cmd_stb = 1'b0;
        cancel  = 1'b0;
        for (int t = 0; t < 3; t++) begin
            sample(t + 1);
            for (int k = 0; k < NI; k++) begin
                n_tests++;
                if (busy[k] !== 1'b0 || err[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cancel_cmd L%0d: got busy=%b err=%b expected 0 0", k + 1, busy[k], err[k]);
                end
            end
            step();
        end
        run_write("after_cancel", 7, 5, 16, 2'b01);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) begin
                logic [1:0] rdy;
                rdy = 2'($urandom_range(1, 3));
                run_write("rand_write", $urandom_range(0, 15), $urandom_range(0, 20),
                          $urandom_range(0, 18), rdy);
            end else begin
                run_read("rand_read", $urandom_range(0, 15), $urandom_range(0, 8), 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_wrap_truncate();
        test_channels();
        test_read();
        test_busy_cmd();
        test_cancel();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
